// File: rtl/jk_seq_pkg.sv
// Shared types and default parameters for the JK flip-flop sequence driver.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        CHECK = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH  = 4;
    localparam int DEFAULT_SETTLE = 1;

endpackage

// File: rtl/jk_excite.sv
// Single-bit JK excitation: derives J/K that move Q to the target T.
// Define JK_SEQ_TOGGLE_EN to encode every change as a toggle (J=K=1).
module jk_excite (
    input  logic q,
    input  logic t,
    output logic j,
    output logic k
);

`ifdef JK_SEQ_TOGGLE_EN
    assign j = q ^ t;
    assign k = q ^ t;
`else
    assign j = ~q & t;
    assign k = q & ~t;
`endif

endmodule

// File: rtl/jk_seq_driver.sv
// Drives an external JK bank to a requested word, waits SETTLE cycles, then checks Q.
// Build option: JK_SEQ_TOGGLE_EN selects toggle encoding inside jk_excite.
module jk_seq_driver
    import jk_seq_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             mismatch,
    output logic [7:0]       err_cnt
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] j_q, k_q;
    logic [WIDTH-1:0] jNext, kNext;
    logic [7:0]       err_q;
    logic             handshake;
    logic             qDiffers;

    for (genvar i = 0; i < WIDTH; i++) begin : g_excite
        jk_excite u_excite (
            .q(q_fb[i]),
            .t(tgt[i]),
            .j(jNext[i]),
            .k(kNext[i])
        );
    end

    assign handshake = tgt_valid && (state_q == IDLE);
    assign qDiffers  = (q_fb != tgt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                state_d = WAIT;
                cnt_d   = SETTLE_LOAD;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // J/K are captured at the handshake so the bank sees them for exactly the DRIVE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            tgt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            err_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (handshake) begin
                tgt_q <= tgt;
                j_q   <= jNext;
                k_q   <= kNext;
            end
            if ((state_q == CHECK) && qDiffers && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign tgt_ready = (state_q == IDLE);
    assign j         = (state_q == DRIVE) ? j_q : '0;
    assign k         = (state_q == DRIVE) ? k_q : '0;
    assign done      = (state_q == CHECK);
    assign mismatch  = done && qDiffers;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_jk_seq_driver.sv
// Self-checking bench for jk_seq_driver with a behavioural JK bank on the feedback path.
module tb_jk_seq_driver;

    localparam int W = 4;

    typedef struct {
        logic [3:0] qInit;
        logic [3:0] tgt;
        logic       stuck;
        logic [3:0] expJ;
        logic [3:0] expK;
        logic       expMis;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         tgtValid, tgtReady, done, mismatch, stuck, loadEn;
    logic [W-1:0] tgt, qFb, j, k, bank, loadVal;
    logic [7:0]   errCnt;

    logic         tgtValid4, tgtReady4, done4, mismatch4, loadEn4;
    logic [W-1:0] tgt4, qFb4, j4, k4, bank4, loadVal4;
    logic [7:0]   errCnt4;

    int passCnt = 0;
    int totalCnt = 0;
    int expErr = 0;

    jk_seq_driver #(.WIDTH(W), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .tgt_valid(tgtValid), .tgt(tgt), .tgt_ready(tgtReady),
        .q_fb(qFb), .j(j), .k(k), .done(done), .mismatch(mismatch), .err_cnt(errCnt)
    );

    jk_seq_driver #(.WIDTH(W), .SETTLE(4)) dut4 (
        .clk(clk), .rst(rst), .tgt_valid(tgtValid4), .tgt(tgt4), .tgt_ready(tgtReady4),
        .q_fb(qFb4), .j(j4), .k(k4), .done(done4), .mismatch(mismatch4), .err_cnt(errCnt4)
    );

    // External JK banks obey Q+ = J&~Q | ~K&Q; stuck pins the first bank's feedback low.
    always @(posedge clk) begin
        if (loadEn) bank <= loadVal;
        else        bank <= (j & ~bank) | (~k & bank);
        if (loadEn4) bank4 <= loadVal4;
        else         bank4 <= (j4 & ~bank4) | (~k4 & bank4);
    end

    assign qFb  = stuck ? '0 : bank;
    assign qFb4 = bank4;

    function automatic void modelJk(input logic [3:0] q, input logic [3:0] t,
                                    output logic [3:0] ej, output logic [3:0] ek);
        logic [3:0] changed;
        changed = q ^ t;
`ifdef JK_SEQ_TOGGLE_EN
        ej = changed;
        ek = changed;
`else
        ej = t & changed;
        ek = q & changed;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Loads the bank, offers one target, and reports J/K in DRIVE, latency to done and mismatch.
    task automatic applyStimulus(input logic [3:0] qInit, input logic [3:0] tv, input logic stuckIn,
                                 output logic [3:0] gotJ, output logic [3:0] gotK,
                                 output int lat, output logic gotMis);
        stuck = stuckIn;
        loadEn = 1'b1;
        loadVal = qInit;
        @(posedge clk); #1;
        loadEn = 1'b0;
        tgtValid = 1'b1;
        tgt = tv;
        @(posedge clk); #1;
        tgtValid = 1'b0;
        @(negedge clk);
        gotJ = j;
        gotK = k;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        gotMis = mismatch;
        @(posedge clk); #1;
    endtask

    task automatic runDut4(input logic [3:0] qInit, input logic [3:0] tv);
        logic [3:0] ej, ek, firstJ, firstK;
        logic jkBad, misAt;
        int doneAt, doneSeen;
        jkBad = 1'b0; misAt = 1'b0; doneAt = -1; doneSeen = 0;
        firstJ = '0; firstK = '0;
        loadEn4 = 1'b1;
        loadVal4 = qInit;
        @(posedge clk); #1;
        loadEn4 = 1'b0;
        tgtValid4 = 1'b1;
        tgt4 = tv;
        @(posedge clk); #1;
        tgtValid4 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                firstJ = j4;
                firstK = k4;
            end else if ((j4 | k4) != '0) begin
                jkBad = 1'b1;
            end
            if (done4) begin
                doneSeen++;
                doneAt = c;
                misAt = mismatch4;
            end
        end
        @(posedge clk); #1;
        modelJk(qInit, tv, ej, ek);
        checkOutput("s4_drive_j", 32'(firstJ), 32'(ej));
        checkOutput("s4_drive_k", 32'(firstK), 32'(ek));
        checkOutput("s4_jk_idle_zero", 32'(jkBad), 32'(0));
        checkOutput("s4_done_count", 32'(doneSeen), 32'(1));
        checkOutput("s4_done_latency", 32'(doneAt), 32'(6));
        checkOutput("s4_mismatch", 32'(misAt), 32'(0));
    endtask

    initial begin
        vec_t vecs[5];
        logic [3:0] gj, gk, ej, ek, qi, tv;
        logic gm, st, em, noDone;
        int lat;
        logic [3:0] seq[5];
        int hsCyc[8];
        int hsCount, doneCnt;

`ifdef JK_SEQ_TOGGLE_EN
        vecs[0] = '{4'b0000, 4'b1010, 1'b0, 4'b1010, 4'b1010, 1'b0};
        vecs[1] = '{4'b1111, 4'b0101, 1'b0, 4'b1010, 4'b1010, 1'b0};
        vecs[2] = '{4'b0000, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1};
        vecs[3] = '{4'b0110, 4'b0110, 1'b0, 4'b0000, 4'b0000, 1'b0};
        vecs[4] = '{4'b1001, 4'b0110, 1'b0, 4'b1111, 4'b1111, 1'b0};
`else
        vecs[0] = '{4'b0000, 4'b1010, 1'b0, 4'b1010, 4'b0000, 1'b0};
        vecs[1] = '{4'b1111, 4'b0101, 1'b0, 4'b0000, 4'b1010, 1'b0};
        vecs[2] = '{4'b0000, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1};
        vecs[3] = '{4'b0110, 4'b0110, 1'b0, 4'b0000, 4'b0000, 1'b0};
        vecs[4] = '{4'b1001, 4'b0110, 1'b0, 4'b0110, 4'b1001, 1'b0};
`endif

        rst = 1'b1;
        tgtValid = 1'b0; tgt = '0; stuck = 1'b0; loadEn = 1'b1; loadVal = '0;
        tgtValid4 = 1'b0; tgt4 = '0; loadEn4 = 1'b1; loadVal4 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(tgtReady), 32'(1));
        checkOutput("rst_j", 32'(j), 32'(0));
        checkOutput("rst_k", 32'(k), 32'(0));
        checkOutput("rst_done", 32'(done), 32'(0));
        checkOutput("rst_mismatch", 32'(mismatch), 32'(0));
        checkOutput("rst_err_cnt", 32'(errCnt), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        loadEn = 1'b0;
        loadEn4 = 1'b0;

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].qInit, vecs[v].tgt, vecs[v].stuck, gj, gk, lat, gm);
            if (vecs[v].expMis) expErr++;
            checkOutput($sformatf("vec%0d_j", v), 32'(gj), 32'(vecs[v].expJ));
            checkOutput($sformatf("vec%0d_k", v), 32'(gk), 32'(vecs[v].expK));
            checkOutput($sformatf("vec%0d_latency", v), 32'(lat), 32'(3));
            checkOutput($sformatf("vec%0d_mismatch", v), 32'(gm), 32'(vecs[v].expMis));
            checkOutput($sformatf("vec%0d_err_cnt", v), 32'(errCnt), 32'(expErr));
        end

        for (int r = 0; r < 40; r++) begin
            qi = 4'($urandom_range(0, 15));
            tv = 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 3) == 0);
            applyStimulus(qi, tv, st, gj, gk, lat, gm);
            modelJk(st ? 4'b0000 : qi, tv, ej, ek);
            em = st && (tv != 4'b0000);
            if (em && expErr < 255) expErr++;
            checkOutput($sformatf("rnd%0d_j", r), 32'(gj), 32'(ej));
            checkOutput($sformatf("rnd%0d_k", r), 32'(gk), 32'(ek));
            checkOutput($sformatf("rnd%0d_latency", r), 32'(lat), 32'(3));
            checkOutput($sformatf("rnd%0d_mismatch", r), 32'(gm), 32'(em));
            checkOutput($sformatf("rnd%0d_err_cnt", r), 32'(errCnt), 32'(expErr));
        end

        // Continuous valid: one accepted target every four cycles, each landing in the bank.
        seq = '{4'h3, 4'hC, 4'h5, 4'h9, 4'hF};
        stuck = 1'b0;
        loadEn = 1'b1; loadVal = '0;
        @(posedge clk); #1;
        loadEn = 1'b0;
        hsCount = 0; doneCnt = 0;
        tgtValid = 1'b1;
        tgt = seq[0];
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            if (tgtReady && hsCount < 8) begin
                hsCyc[hsCount] = cyc;
                hsCount++;
            end
            if (done) begin
                checkOutput($sformatf("cont_bank%0d", doneCnt), 32'(qFb), 32'(seq[doneCnt % 5]));
                checkOutput($sformatf("cont_mis%0d", doneCnt), 32'(mismatch), 32'(0));
                doneCnt++;
            end
            @(posedge clk); #1;
            tgt = seq[hsCount % 5];
        end
        tgtValid = 1'b0;
        checkOutput("cont_handshakes", 32'(hsCount), 32'(6));
        checkOutput("cont_dones", 32'(doneCnt), 32'(6));
        for (int h = 0; h < 6 && h < hsCount; h++)
            checkOutput($sformatf("cont_hs_cycle%0d", h), 32'(hsCyc[h]), 32'(4 * h));

        // Reset during WAIT aborts the step and clears the error count.
        tgtValid = 1'b1;
        tgt = 4'b0110;
        @(posedge clk); #1;
        tgtValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("wait_rst_no_done", 32'(done), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("wait_rst_ready", 32'(tgtReady), 32'(1));
        checkOutput("wait_rst_err_cnt", 32'(errCnt), 32'(0));
        checkOutput("wait_rst_jk", 32'({j, k}), 32'(0));
        noDone = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) noDone = 1'b0;
        end
        checkOutput("wait_rst_quiet", 32'(noDone), 32'(1));
        @(posedge clk); #1;
        expErr = 0;

        // Stuck feedback drives the error count up to saturation.
        for (int s = 0; s < 300; s++) begin
            applyStimulus(4'b0000, 4'b0001, 1'b1, gj, gk, lat, gm);
            if (expErr < 255) expErr++;
            if (s == 0) begin
                checkOutput("sat_first_mismatch", 32'(gm), 32'(1));
                checkOutput("sat_first_err_cnt", 32'(errCnt), 32'(1));
            end
        end
        checkOutput("sat_err_cnt", 32'(errCnt), 32'(expErr));
        checkOutput("sat_latency", 32'(lat), 32'(3));
        stuck = 1'b0;

        // Reset wins over a simultaneous handshake.
        rst = 1'b1;
        tgtValid = 1'b1;
        tgt = 4'b1111;
        @(posedge clk); #1;
        rst = 1'b0;
        tgtValid = 1'b0;
        @(negedge clk);
        checkOutput("rst_hs_ready", 32'(tgtReady), 32'(1));
        checkOutput("rst_hs_j", 32'(j), 32'(0));
        noDone = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done) noDone = 1'b0;
        end
        checkOutput("rst_hs_quiet", 32'(noDone), 32'(1));
        @(posedge clk); #1;

        runDut4(4'b0110, 4'b0110);
        runDut4(4'b0011, 4'b1100);
        checkOutput("s4_err_cnt", 32'(errCnt4), 32'(0));

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
